// File: rtl/bp_me_mem_ordered_router.sv
// Ordered memory router: steers commands to the L2 slice or config device
// and returns responses strictly in acceptance order via a tag FIFO.
package bp_me_mem_ordered_router_pkg;

    typedef enum logic [3:0] {
        e_bp_inv_cfg = 4'd0
    } bp_params_e;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 64;
    localparam int lce_id_width_p    = 4;
    localparam int lce_assoc_p       = 8;
    localparam int way_id_width_lp   = $clog2(lce_assoc_p);

    typedef struct packed {
        logic [lce_id_width_p-1:0]  lce_id;
        logic [way_id_width_lp-1:0] way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [3:0]               msg_type;
        logic [paddr_width_p-1:0] addr;
        logic [2:0]               size;
        bp_cce_mem_payload_s      payload;
    } bp_cce_mem_header_s;

    typedef struct packed {
        bp_cce_mem_header_s           header;
        logic [cce_block_width_p-1:0] data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

module bp_me_mem_ordered_router
    import bp_me_mem_ordered_router_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int max_outstanding_p = 4,
    parameter int cfg_device_id_p = 1,
    localparam int msg_width_lp = cce_mem_msg_width_lp,
    localparam int cnt_width_lp = $clog2(max_outstanding_p+1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [msg_width_lp-1:0] mem_cmd_i,
    input  logic                    mem_cmd_v_i,
    output logic                    mem_cmd_ready_o,
    output logic [msg_width_lp-1:0] mem_resp_o,
    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_yumi_i,
    output logic [msg_width_lp-1:0] cache_cmd_o,
    output logic                    cache_cmd_v_o,
    input  logic                    cache_cmd_ready_i,
    input  logic [msg_width_lp-1:0] cache_resp_i,
    input  logic                    cache_resp_v_i,
    output logic                    cache_resp_yumi_o,
    output logic [msg_width_lp-1:0] cfg_cmd_o,
    output logic                    cfg_cmd_v_o,
    input  logic                    cfg_cmd_ready_i,
    input  logic [msg_width_lp-1:0] cfg_resp_i,
    input  logic                    cfg_resp_v_i,
    output logic                    cfg_resp_yumi_o,
    output logic [cnt_width_lp-1:0] outstanding_o,
    output logic [15:0]             err_cnt_o
);

    localparam logic [1:0] dest_cache_lp = 2'd0;
    localparam logic [1:0] dest_cfg_lp   = 2'd1;
    localparam logic [1:0] dest_err_lp   = 2'd2;
    localparam int ptr_width_lp = $clog2(max_outstanding_p);

    bp_cce_mem_msg_s    cmd;
    bp_cce_mem_msg_s    resp_sel;
    bp_cce_mem_header_s err_r;
    logic               err_v_r;
    logic [15:0]        err_cnt_r;

    logic [1:0]              tags_r [max_outstanding_p];
    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic [1:0]              dest, head;
    logic                    is_cache, is_cfg;
    logic                    full, empty, target_ready, push, pop;

    assign cmd      = mem_cmd_i;
    assign is_cache = |cmd.header.addr[paddr_width_p-1:31];
    assign is_cfg   = ~is_cache
                    & (cmd.header.addr[23:20] == 4'(cfg_device_id_p));

    // Destination decode of the incoming command
    always_comb begin
        unique case (1'b1)
            is_cache: dest = dest_cache_lp;
            is_cfg:   dest = dest_cfg_lp;
            default:  dest = dest_err_lp;
        endcase
    end

    assign full  = (count_r == cnt_width_lp'(max_outstanding_p));
    assign empty = (count_r == '0);
    assign head  = tags_r[rptr_r];

    // Readiness of the selected target; ERR slot holds one header
    always_comb begin
        unique case (dest)
            dest_cache_lp: target_ready = cache_cmd_ready_i;
            dest_cfg_lp:   target_ready = cfg_cmd_ready_i;
            default:       target_ready = ~err_v_r;
        endcase
    end

    assign cache_cmd_o     = mem_cmd_i;
    assign cfg_cmd_o       = mem_cmd_i;
    assign cache_cmd_v_o   = ~reset_i & mem_cmd_v_i & ~full
                           & (dest == dest_cache_lp);
    assign cfg_cmd_v_o     = ~reset_i & mem_cmd_v_i & ~full
                           & (dest == dest_cfg_lp);
    assign mem_cmd_ready_o = ~reset_i & ~full & target_ready;
    assign push            = mem_cmd_v_i & mem_cmd_ready_o;

    // Response mux steered by the oldest outstanding tag
    always_comb begin
        resp_sel     = '0;
        mem_resp_v_o = 1'b0;
        unique case (head)
            dest_cache_lp: begin
                resp_sel     = cache_resp_i;
                mem_resp_v_o = cache_resp_v_i;
            end
            dest_cfg_lp: begin
                resp_sel     = cfg_resp_i;
                mem_resp_v_o = cfg_resp_v_i;
            end
            default: begin
                resp_sel.header = err_r;
                mem_resp_v_o    = err_v_r;
            end
        endcase
        mem_resp_v_o = mem_resp_v_o & ~empty & ~reset_i;
    end

    assign mem_resp_o        = resp_sel;
    assign pop               = mem_resp_yumi_i & mem_resp_v_o;
    assign cache_resp_yumi_o = pop & (head == dest_cache_lp);
    assign cfg_resp_yumi_o   = pop & (head == dest_cfg_lp);
    assign outstanding_o     = count_r;
    assign err_cnt_o         = err_cnt_r;

    // Tag storage; contents only meaningful below count_r
    always_ff @(posedge clk_i) begin
        if (push)
            tags_r[wptr_r] <= dest;
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push)
                wptr_r <= wptr_r + 1'b1;
            if (pop)
                rptr_r <= rptr_r + 1'b1;
            count_r <= count_r + cnt_width_lp'(push)
                               - cnt_width_lp'(pop);
        end
    end

    // Error slot: capture header, flag, and saturating counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_v_r   <= 1'b0;
            err_cnt_r <= '0;
        end else if (push && dest == dest_err_lp) begin
            err_v_r <= 1'b1;
            if (err_cnt_r != 16'hFFFF)
                err_cnt_r <= err_cnt_r + 16'd1;
        end else if (pop && head == dest_err_lp) begin
            err_v_r <= 1'b0;
        end
    end

    // Header of the error command awaiting its synthetic response
    always_ff @(posedge clk_i) begin
        if (push && dest == dest_err_lp)
            err_r <= cmd.header;
    end

    logic                    has_cache, has_cfg;
    logic [ptr_width_lp-1:0] idx;

    // Which sources have at least one outstanding tag
    always_comb begin
        has_cache = 1'b0;
        has_cfg   = 1'b0;
        idx       = '0;
        for (int i = 0; i < max_outstanding_p; i++) begin
            if (cnt_width_lp'(i) < count_r) begin
                idx = rptr_r + ptr_width_lp'(i);
                if (tags_r[idx] == dest_cache_lp)
                    has_cache = 1'b1;
                if (tags_r[idx] == dest_cfg_lp)
                    has_cfg = 1'b1;
            end
        end
    end

    // Protocol checks on the upstream and downstream response ports
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (bp_params_p == e_bp_inv_cfg)
                else $error("router: unsupported bp_params_p");
            assert (!(mem_resp_yumi_i && !mem_resp_v_o))
                else $error("router: yumi without valid");
            assert (!(cache_resp_v_i && !has_cache))
                else $error("router: unexpected cache response");
            assert (!(cfg_resp_v_i && !has_cfg))
                else $error("router: unexpected cfg response");
        end
    end

endmodule
